bp_update_arbiter: RTL and testbench
====================================

Name: bp_update_arbiter

Overview:
Dual-lane branch-resolution arbiter for the global-history predictor. It accepts up to two resolved branches per cycle from execute lanes 0 and 1, and keeps them in program order in a small FIFO. It drains one entry per cycle into the predictor's single GHR/PHT update port. It sits between the execute-stage branch units and the global history predictor.

Parameters:
PC_W, 32, width of the branch PC carried with each update
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
br0_valid  in  1  lane 0 resolved branch valid (older of the pair)
br0_ready  out  1  lane 0 accepted this cycle if valid
br0_taken  in  1  lane 0 branch outcome
br0_pc  in  PC_W  lane 0 branch PC
br1_valid  in  1  lane 1 resolved branch valid (younger)
br1_ready  out  1  lane 1 accepted this cycle if valid
br1_taken  in  1  lane 1 branch outcome
br1_pc  in  PC_W  lane 1 branch PC
flush  in  1  pipeline flush; discard all buffered updates
upd_valid  out  1  update available to predictor
upd_ready  in  1  predictor consumes update this cycle
upd_taken  out  1  outcome at FIFO head
upd_pc  out  PC_W  PC at FIFO head
occupancy  out  CNT_W  current FIFO entry count

Behaviour:
- Reset (rst=0, async): rd_ptr, wr_ptr, count = 0. Outputs: upd_valid=0, occupancy=0, upd_taken=0, upd_pc=0. br0_ready=1 and br1_ready=1 follow from free=DEPTH.
- free = DEPTH - count, computed from the registered count only. No same-cycle credit for a drain.
- br0_ready = (free >= 1) && !flush.
- br1_ready = ((free >= 2) || (free == 1 && !br0_valid)) && !flush.
- Ordering: if both lanes are accepted, lane 0 goes to wr_ptr and lane 1 to wr_ptr+1. If only lane 1 is accepted, it goes to wr_ptr. wr_ptr advances by the number accepted (0/1/2).
- Lane 1 is never accepted while lane 0 is valid and rejected. Program order is preserved.
- Drain: upd_valid = (count != 0). upd_taken and upd_pc are the registered head entry, driven combinationally from storage[rd_ptr].
- Handshake: upd_valid && upd_ready pops the head; rd_ptr advances by 1.
- upd_valid, upd_taken and upd_pc are held stable while upd_valid && !upd_ready.
- Latency: an entry accepted at edge N is visible on upd_* after edge N (next cycle) if it is at the head. No combinational bypass from br* to upd*.
- Count update: count_next = count + accepted - popped. Simultaneous 2-push + 1-pop when free >= 2 is legal, giving a net +1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Full (count == DEPTH): both readies are 0; a pop in the same cycle does not make room until the next cycle.
- Empty: upd_valid=0; upd_ready is ignored.
- Flush: synchronous. At the next edge rd_ptr = wr_ptr = count = 0.
  - Readies are forced to 0 during flush, so no same-cycle pushes.
  - A pop handshake in the flush cycle is honoured by the predictor but has no effect on the cleared state.
- Async reset asserted mid-operation clears all state immediately, regardless of pending handshakes.
- Storage contents are not reset; only pointers and count are.

Decomposition:
- Shared package bp_pkg:
  - typedef bp_update_t {logic taken; logic [PC_W-1:0] pc;}
  - BP_UPD_DEPTH default constant
- Natural sub-module: bp_upd_fifo2w1r, a 2-write/1-read circular buffer holding storage, pointers and count.
- The arbiter top holds the ready/ordering logic and flush gating.

Test Plan:
- Reset then idle: rst low 2 cycles, release. Expect upd_valid=0, occupancy=0, br0_ready=br1_ready=1.
- Dual push, ordering: one cycle with br0 (taken=1, pc=0x100) and br1 (taken=0, pc=0x104), upd_ready=0. Next cycle occupancy=2 and head is pc=0x100/taken=1. With upd_ready=1 the pops come out 0x100 then 0x104.
- Fill/backpressure:
  - upd_ready=0, push pairs until occupancy=4. Then both readies are 0 and further valids are not accepted.
  - At occupancy=3 with both valid: br0_ready=1, br1_ready=0.
  - At occupancy=3 with only br1 valid: br1_ready=1.
- Concurrent push/pop at occupancy=2: push 2 and pop 1 in the same cycle. Next cycle occupancy=3, and the FIFO order is preserved across pointer wrap, checked by pushing 10 sequential PCs 0x200..0x224.
- Flush at occupancy=3 while both lanes are valid: both readies are 0 that cycle. Next cycle occupancy=0 and upd_valid=0. Subsequent pushes go out in the correct order.
- Async reset mid-stream: assert rst between edges at occupancy=2. upd_valid and occupancy drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch-predictor update path.
// Holds the update record and the default FIFO depth.
package bp_pkg;

   localparam int BP_PC_W      = 32;
   localparam int BP_UPD_DEPTH = 4;

   typedef struct packed {
      logic               taken;
      logic [BP_PC_W-1:0] pc;
   } bp_update_t;

endpackage

// File: rtl/bp_upd_fifo2w1r.sv
// Two-write / one-read circular buffer for predictor updates.
// Ports: clk, rst (async low), clr (sync clear), we0/wd0 -> wr_ptr,
//        we1/wd1 -> wr_ptr+1 (only with we0), pop, head, count.
module bp_upd_fifo2w1r
   import bp_pkg::*;
#(
   parameter int  DEPTH   = BP_UPD_DEPTH,
   parameter type entry_t = bp_update_t,
   parameter int  CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             we0,
   input  entry_t           wd0,
   input  logic             we1,
   input  entry_t           wd1,
   input  logic             pop,
   output entry_t           head,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] wr_ptr1;
   logic [CNT_W-1:0] n_push;
   logic             do_pop;

   assign wr_ptr1 = wr_ptr + PTR_W'(1);
   assign n_push  = CNT_W'(we0) + CNT_W'(we1);
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(n_push);
         rd_ptr <= rd_ptr + PTR_W'(do_pop);
         count  <= count + n_push - CNT_W'(do_pop);
      end
   end

   // Payload storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we0) mem[wr_ptr]  <= wd0;
      if (we1) mem[wr_ptr1] <= wd1;
   end

endmodule

// File: rtl/bp_update_arbiter.sv
// Dual-lane branch-resolution arbiter feeding the GHR/PHT update port.
// Ports: br0_*/br1_* resolved branches, flush, upd_* drain, occupancy.
module bp_update_arbiter
   import bp_pkg::*;
#(
   parameter int PC_W  = BP_PC_W,
   parameter int DEPTH = BP_UPD_DEPTH,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             br0_valid,
   output logic             br0_ready,
   input  logic             br0_taken,
   input  logic [PC_W-1:0]  br0_pc,
   input  logic             br1_valid,
   output logic             br1_ready,
   input  logic             br1_taken,
   input  logic [PC_W-1:0]  br1_pc,
   input  logic             flush,
   output logic             upd_valid,
   input  logic             upd_ready,
   output logic             upd_taken,
   output logic [PC_W-1:0]  upd_pc,
   output logic [CNT_W-1:0] occupancy
);

   typedef struct packed {
      logic            taken;
      logic [PC_W-1:0] pc;
   } upd_t;

   upd_t             e0;
   upd_t             e1;
   upd_t             wd0;
   upd_t             head;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] free;
   logic             acc0;
   logic             acc1;
   logic             we0;
   logic             we1;

   assign e0 = '{taken: br0_taken, pc: br0_pc};
   assign e1 = '{taken: br1_taken, pc: br1_pc};

   // Free space uses the registered count only: a drain this
   // cycle does not open a slot until the next one.
   assign free = CNT_W'(DEPTH) - count;

   assign br0_ready = (free != '0) && !flush;
   // Lane 1 may take the last slot only when lane 0 is idle,
   // so a younger branch never overtakes a stalled older one.
   assign br1_ready = ((free >= CNT_W'(2)) ||
                       (free == CNT_W'(1) && !br0_valid)) && !flush;

   assign acc0 = br0_valid && br0_ready;
   assign acc1 = br1_valid && br1_ready;

   // Oldest accepted entry always lands at wr_ptr.
   assign we0 = acc0 || acc1;
   assign we1 = acc0 && acc1;
   assign wd0 = acc0 ? e0 : e1;

   bp_upd_fifo2w1r #(
      .DEPTH   (DEPTH),
      .entry_t (upd_t),
      .CNT_W   (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .we0   (we0),
      .wd0   (wd0),
      .we1   (we1),
      .wd1   (e1),
      .pop   (upd_valid && upd_ready),
      .head  (head),
      .count (count)
   );

   assign upd_valid = (count != '0);
   // Mask the unreset storage so an empty FIFO presents zeros.
   assign upd_taken = upd_valid ? head.taken : 1'b0;
   assign upd_pc    = upd_valid ? head.pc : '0;
   assign occupancy = count;

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Scoreboard bench for bp_update_arbiter.
// Pushes expected updates on accept, pops them on each drain handshake.
module tb_bp_update_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        br0_valid, br0_ready, br0_taken;
   logic [31:0] br0_pc;
   logic        br1_valid, br1_ready, br1_taken;
   logic [31:0] br1_pc;
   logic        flush;
   logic        upd_valid, upd_ready, upd_taken;
   logic [31:0] upd_pc;
   logic [2:0]  occupancy;

   int total = 0;
   int bad   = 0;

   logic [32:0] sb [$];
   int          m_cnt = 0;

   always #5 clk = ~clk;

   bp_update_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .br0_valid (br0_valid),
      .br0_ready (br0_ready),
      .br0_taken (br0_taken),
      .br0_pc    (br0_pc),
      .br1_valid (br1_valid),
      .br1_ready (br1_ready),
      .br1_taken (br1_taken),
      .br1_pc    (br1_pc),
      .flush     (flush),
      .upd_valid (upd_valid),
      .upd_ready (upd_ready),
      .upd_taken (upd_taken),
      .upd_pc    (upd_pc),
      .occupancy (occupancy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v0, input logic t0,
                        input logic [31:0] p0,
                        input logic v1, input logic t1,
                        input logic [31:0] p1);
      br0_valid = v0; br0_taken = t0; br0_pc = p0;
      br1_valid = v1; br1_taken = t1; br1_pc = p1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   // Reference model: sampled on the falling edge, mid-cycle.
   task automatic scoreboard_mon();
      int          free;
      logic        r0, r1, a0, a1, popd;
      logic [32:0] exp_e;
      forever begin
         @(negedge clk or negedge rst);
         if (!rst) begin
            m_cnt = 0;
            sb.delete();
         end else begin
            free = 4 - m_cnt;
            r0 = (free >= 1) && !flush;
            r1 = ((free >= 2) || (free == 1 && !br0_valid)) && !flush;
            total++;
            if (br0_ready !== r0) begin
               bad++;
               $display("FAIL mon_br0_ready got %b want %b", br0_ready, r0);
            end
            total++;
            if (br1_ready !== r1) begin
               bad++;
               $display("FAIL mon_br1_ready got %b want %b", br1_ready, r1);
            end
            total++;
            if (occupancy !== 3'(m_cnt)) begin
               bad++;
               $display("FAIL mon_occ got %0d want %0d", occupancy, m_cnt);
            end
            total++;
            if (upd_valid !== (m_cnt != 0)) begin
               bad++;
               $display("FAIL mon_upd_valid got %b want %b", upd_valid, m_cnt != 0);
            end
            popd = (m_cnt != 0) && upd_ready;
            if (popd) begin
               total++;
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL sb_underflow got pop want none");
               end else begin
                  exp_e = sb.pop_front();
                  if ({upd_taken, upd_pc} !== exp_e) begin
                     bad++;
                     $display("FAIL sb_head got %b/%h want %b/%h",
                              upd_taken, upd_pc, exp_e[32], exp_e[31:0]);
                  end
               end
            end
            a0 = br0_valid && r0;
            a1 = br1_valid && r1;
            if (a0) sb.push_back({br0_taken, br0_pc});
            if (a1) sb.push_back({br1_taken, br1_pc});
            if (flush) begin
               sb.delete();
               m_cnt = 0;
            end else begin
               m_cnt = m_cnt + int'(a0) + int'(a1) - int'(popd);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      #1;
      total++;
      if (upd_valid !== 1'b0) begin
         bad++; $display("FAIL rst_upd_valid got %b want 0", upd_valid);
      end
      total++;
      if (occupancy !== 3'd0) begin
         bad++; $display("FAIL rst_occ got %0d want 0", occupancy);
      end
      total++;
      if (br0_ready !== 1'b1 || br1_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_readies got %b%b want 11", br0_ready, br1_ready);
      end
      total++;
      if (upd_pc !== 32'h0 || upd_taken !== 1'b0) begin
         bad++;
         $display("FAIL rst_upd_data got %b/%h want 0/0", upd_taken, upd_pc);
      end
   endtask

   task automatic test_dual_push();
      upd_ready = 1'b0;
      drive(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h104);
      step();
      idle();
      total++;
      if (occupancy !== 3'd2) begin
         bad++; $display("FAIL dual_occ got %0d want 2", occupancy);
      end
      total++;
      if (upd_pc !== 32'h100 || upd_taken !== 1'b1) begin
         bad++;
         $display("FAIL dual_head got %b/%h want 1/100", upd_taken, upd_pc);
      end
      step();
      total++;
      if (upd_pc !== 32'h100) begin
         bad++; $display("FAIL dual_hold got %h want 100", upd_pc);
      end
      upd_ready = 1'b1;
      repeat (2) step();
      upd_ready = 1'b0;
      total++;
      if (occupancy !== 3'd0 || sb.size() != 0) begin
         bad++;
         $display("FAIL dual_drain got occ=%0d sb=%0d want 0/0",
                  occupancy, sb.size());
      end
   endtask

   task automatic test_fill();
      upd_ready = 1'b0;
      drive(1'b1, 1'b0, 32'h300, 1'b1, 1'b1, 32'h304);
      step();
      drive(1'b1, 1'b1, 32'h308, 1'b1, 1'b0, 32'h30c);
      step();
      drive(1'b1, 1'b1, 32'h3f0, 1'b1, 1'b1, 32'h3f4);
      #1;
      total++;
      if (occupancy !== 3'd4) begin
         bad++; $display("FAIL fill_occ got %0d want 4", occupancy);
      end
      total++;
      if (br0_ready !== 1'b0 || br1_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_readies got %b%b want 00", br0_ready, br1_ready);
      end
      step();
      idle();
      total++;
      if (occupancy !== 3'd4) begin
         bad++; $display("FAIL full_hold got %0d want 4", occupancy);
      end
      upd_ready = 1'b1;
      step();
      upd_ready = 1'b0;
      drive(1'b1, 1'b1, 32'h3f8, 1'b1, 1'b1, 32'h3fc);
      #1;
      total++;
      if (br0_ready !== 1'b1 || br1_ready !== 1'b0) begin
         bad++;
         $display("FAIL occ3_both got %b%b want 10", br0_ready, br1_ready);
      end
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3fc);
      #1;
      total++;
      if (br1_ready !== 1'b1) begin
         bad++; $display("FAIL occ3_lane1 got %b want 1", br1_ready);
      end
      idle();
      upd_ready = 1'b1;
      repeat (3) step();
      upd_ready = 1'b0;
      total++;
      if (occupancy !== 3'd0 || sb.size() != 0) begin
         bad++;
         $display("FAIL fill_drain got occ=%0d sb=%0d want 0/0",
                  occupancy, sb.size());
      end
   endtask

   task automatic test_concurrent_wrap();
      logic [31:0] pc;
      upd_ready = 1'b0;
      drive(1'b1, 1'b0, 32'h200, 1'b1, 1'b1, 32'h204);
      step();
      upd_ready = 1'b1;
      drive(1'b1, 1'b0, 32'h208, 1'b1, 1'b1, 32'h20c);
      step();
      idle();
      upd_ready = 1'b0;
      total++;
      if (occupancy !== 3'd3) begin
         bad++; $display("FAIL conc_occ got %0d want 3", occupancy);
      end
      upd_ready = 1'b1;
      for (int i = 4; i < 10; i++) begin
         pc = 32'h200 + 32'(4 * i);
         if (i % 2 == 0) drive(1'b1, i[0], pc, 1'b0, 1'b0, 32'h0);
         else            drive(1'b0, 1'b0, 32'h0, 1'b1, i[0], pc);
         step();
      end
      idle();
      repeat (3) step();
      upd_ready = 1'b0;
      total++;
      if (occupancy !== 3'd0 || sb.size() != 0) begin
         bad++;
         $display("FAIL wrap_drain got occ=%0d sb=%0d want 0/0",
                  occupancy, sb.size());
      end
   endtask

   task automatic test_flush();
      upd_ready = 1'b0;
      drive(1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 32'h504);
      step();
      drive(1'b1, 1'b1, 32'h508, 1'b0, 1'b0, 32'h0);
      step();
      drive(1'b1, 1'b0, 32'h50c, 1'b1, 1'b1, 32'h510);
      flush = 1'b1;
      upd_ready = 1'b1;
      #1;
      total++;
      if (br0_ready !== 1'b0 || br1_ready !== 1'b0) begin
         bad++;
         $display("FAIL flush_readies got %b%b want 00", br0_ready, br1_ready);
      end
      step();
      flush = 1'b0;
      upd_ready = 1'b0;
      idle();
      total++;
      if (occupancy !== 3'd0 || upd_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_clear got occ=%0d v=%b want 0/0",
                  occupancy, upd_valid);
      end
      drive(1'b1, 1'b0, 32'h600, 1'b1, 1'b1, 32'h604);
      step();
      idle();
      total++;
      if (upd_pc !== 32'h600) begin
         bad++; $display("FAIL post_flush_head got %h want 600", upd_pc);
      end
      upd_ready = 1'b1;
      repeat (2) step();
      upd_ready = 1'b0;
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL post_flush_sb got %0d want 0", sb.size());
      end
   endtask

   task automatic test_async_reset();
      upd_ready = 1'b0;
      drive(1'b1, 1'b1, 32'h700, 1'b1, 1'b1, 32'h704);
      step();
      idle();
      #2;
      rst = 1'b0;
      #1;
      total++;
      if (upd_valid !== 1'b0 || occupancy !== 3'd0) begin
         bad++;
         $display("FAIL async_rst got v=%b occ=%0d want 0/0",
                  upd_valid, occupancy);
      end
      step();
      rst = 1'b1;
      #1;
      total++;
      if (br0_ready !== 1'b1 || br1_ready !== 1'b1 || occupancy !== 3'd0) begin
         bad++;
         $display("FAIL async_release got %b%b occ=%0d want 11/0",
                  br0_ready, br1_ready, occupancy);
      end
   endtask

   initial begin
      rst = 1'b0;
      flush = 1'b0;
      upd_ready = 1'b0;
      idle();
      fork
         scoreboard_mon();
      join_none
      test_reset();
      test_dual_push();
      test_fill();
      test_concurrent_wrap();
      test_flush();
      test_async_reset();
      repeat (2) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
